pe_job_scheduler: RTL and testbench
===================================

// Module: pe_job_scheduler
// PURPOSE
//  Sequences one bit-brick PE (16 x 2b bricks, 13b signed product, shift 0/2/4, 1-cycle registered output) over a job of N operand beats.
//  Accepts pre-sliced 32b activation/weight brick-planes on a valid/ready stream and drives the PE operand, sign and shift inputs.
//  Tags in-flight beats across the PE latency, accumulates the signed products and returns one result per job on an output handshake.
//  Sits between the operand fetch/slicing logic and the PE array's per-PE result path.
// PARAMETERS
//  LEN_W   8   width of job length (beats per job, 0..2^LEN_W-1)
//  PROD_W  13  PE product width (signed)
//  ACC_W   24  accumulator / o_sum width (signed, two's-complement wrap)
// PORTS
//  i_clk             in   1       clock; one clock domain
//  i_rst             in   1       reset, synchronous, active-high
//  i_start           in   1       start job (sampled in IDLE only)
//  i_len             in   LEN_W   beats in job, latched on accepted start
//  o_busy            out  1       1 in any state except IDLE
//  i_valid           in   1       operand beat valid
//  o_ready           out  1       scheduler accepts beat (RUN only)
//  i_act / i_wgt     in   32      activation / weight brick-plane
//  i_a_signed/i_w_signed in 1     sign mode for this beat
//  i_shift           in   4       shift code for this beat (legal: 0,2,4)
//  o_pe_activation   out  32      to PE i_activation
//  o_pe_weight       out  32      to PE i_weight
//  o_pe_A_signed/o_pe_W_signed out 1  to PE sign inputs
//  o_pe_shift_amount out  4       to PE i_shift_amount
//  i_pe_prod         in   PROD_W  PE o_prod (signed)
//  o_valid           out  1       job result valid (DONE)
//  i_ready           in   1       consumer accepts result
//  o_sum             out  ACC_W   accumulated signed result
//  o_err             out  1       sticky: illegal shift code seen this job
// BEHAVIOUR
//  Reset (i_rst=1 at edge): state IDLE; acc, remaining count, in-flight tag, o_err cleared; o_valid=0, o_ready=0, o_busy=0, o_sum=0.
//  accept = i_valid & o_ready. PE drive is combinational: accept ? beat fields : all zero (incl. signed=0, shift=0).
//  In-flight tag: tag <= accept. Cycle after accept, if tag=1: acc <= acc + sext(i_pe_prod); tag=0 -> product ignored.
//  FSM:
//   IDLE : o_ready=0. i_start -> acc=0, err=0, rem=i_len; i_len=0 -> DONE, else -> RUN.
//   RUN  : o_ready=1. On accept rem--; accept with rem==1 -> DRAIN. No accept -> stay (gaps allowed, no timeout).
//   DRAIN: o_ready=0; last product added this cycle -> DONE.
//   DONE : o_valid=1, o_sum=acc held stable; o_valid & i_ready -> IDLE. i_start ignored.
//  i_start outside IDLE ignored; no queuing.
//  Latency: last beat accepted in cycle t -> o_valid=1 from cycle t+2. Single-beat job: start in c0, beat c1, o_valid c3.
//  Throughput: 1 beat/cycle in RUN; 3 cycles overhead per job (start, drain, done handshake min 1).
//  i_shift not in {0,2,4}: beat still accepted and forwarded (PE applies no shift); o_err set, held until next accepted start.
//  Accumulator wraps modulo 2^ACC_W; no saturation, no overflow flag.
//  Reset mid-job: abort immediately to IDLE, no o_valid. PE output register is not reset by i_rst; cleared tag guarantees stale PE product never accumulated.
// TESTING
//  T1 len=1, act=wgt=32'h1, unsigned, shift 0 -> o_valid at start+3 cycles, o_sum=1, o_err=0.
//  T2 len=3, act=wgt=32'hFFFF_FFFF, both signed, shifts 0,2,4 -> 16+64+256, o_sum=336.
//  T3 len=4 as T1 beats, i_valid toggling 1/0 each cycle -> exactly 4 accepts, o_sum=4; i_len=0 -> o_valid next cycle, o_sum=0.
//  T4 DONE with i_ready=0 for 5 cycles, i_start pulsed -> o_valid/o_sum stable, start ignored, IDLE after i_ready.
//  T5 beat with shift=3 (T1 operands) -> o_sum=1, o_err=1; following legal job -> o_err=0.
//  T6 i_rst after 2 of 4 beats -> IDLE, no o_valid; next len=1 job of T1 -> o_sum=1 (stale PE output not added).

Source files
------------

// File: rtl/pe_job_scheduler.sv
// Job sequencer for one bit-brick PE: streams operand beats into the PE, tracks
// which PE products belong to accepted beats and returns one accumulated sum per job.
module pe_job_scheduler #(
    parameter int LEN_W  = 8,
    parameter int PROD_W = 13,
    parameter int ACC_W  = 24
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_busy,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_act,
    input  logic [31:0]       i_wgt,
    input  logic              i_a_signed,
    input  logic              i_w_signed,
    input  logic [3:0]        i_shift,
    output logic [31:0]       o_pe_activation,
    output logic [31:0]       o_pe_weight,
    output logic              o_pe_A_signed,
    output logic              o_pe_W_signed,
    output logic [3:0]        o_pe_shift_amount,
    input  logic [PROD_W-1:0] i_pe_prod,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic shift_legal(input logic [3:0] sh);
        logic ok;
        case (sh)
            4'd0, 4'd2, 4'd4: ok = 1'b1;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               tag_q, tag_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic               accept;
    logic [ACC_W-1:0]   prod_ext;

    assign accept   = i_valid & ready_q;
    assign prod_ext = {{(ACC_W-PROD_W){i_pe_prod[PROD_W-1]}}, i_pe_prod};

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_sum   = sum_q;
    assign o_err   = err_q;

    // PE operand drive: beat fields only on an accepted beat, idle zeros otherwise
    always_comb begin
        if (accept) begin
            o_pe_activation   = i_act;
            o_pe_weight       = i_wgt;
            o_pe_A_signed     = i_a_signed;
            o_pe_W_signed     = i_w_signed;
            o_pe_shift_amount = i_shift;
        end else begin
            o_pe_activation   = 32'd0;
            o_pe_weight       = 32'd0;
            o_pe_A_signed     = 1'b0;
            o_pe_W_signed     = 1'b0;
            o_pe_shift_amount = 4'd0;
        end
    end

    // Next-state, accumulation and registered-output computation
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        tag_d   = accept;
        err_d   = err_q;

        // A product arriving now belongs to the beat accepted one cycle ago
        if (tag_q) begin
            acc_d = acc_q + prod_ext;
        end else begin
            acc_d = acc_q;
        end

        if (accept && !shift_legal(i_shift)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    acc_d = {ACC_W{1'b0}};
                    err_d = 1'b0;
                    rem_d = i_len;
                    if (i_len == {LEN_W{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (accept) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (valid_q && i_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_RUN);
        valid_d = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
        if (state_d == S_DONE) begin
            sum_d = acc_d;
        end else begin
            sum_d = {ACC_W{1'b0}};
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            rem_q   <= {LEN_W{1'b0}};
            acc_q   <= {ACC_W{1'b0}};
            tag_q   <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            sum_q   <= {ACC_W{1'b0}};
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            tag_q   <= tag_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            sum_q   <= sum_d;
        end
    end

endmodule

// File: tb/tb_pe_job_scheduler.sv
// Self-checking bench for pe_job_scheduler: a behavioural PE model feeds products back,
// table vectors and random jobs are compared against sums computed from the stimulus.
module tb_pe_job_scheduler;
    localparam int LEN_W  = 8;
    localparam int PROD_W = 13;
    localparam int ACC_W  = 24;

    logic              clk = 1'b0;
    logic              i_rst, i_start, i_valid, i_a_signed, i_w_signed, i_ready;
    logic [LEN_W-1:0]  i_len;
    logic [31:0]       i_act, i_wgt;
    logic [3:0]        i_shift;
    logic              o_busy, o_ready, o_pe_A_signed, o_pe_W_signed, o_valid, o_err;
    logic [31:0]       o_pe_activation, o_pe_weight;
    logic [3:0]        o_pe_shift_amount;
    logic [PROD_W-1:0] pe_q;
    logic [ACC_W-1:0]  o_sum;

    int checks = 0;
    int errors = 0;

    logic [31:0] b_act [16];
    logic [31:0] b_wgt [16];
    logic        b_as  [16];
    logic        b_ws  [16];
    logic [3:0]  b_sh  [16];

    always #5 clk = ~clk;

    pe_job_scheduler #(.LEN_W(LEN_W), .PROD_W(PROD_W), .ACC_W(ACC_W)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len), .o_busy(o_busy),
        .i_valid(i_valid), .o_ready(o_ready), .i_act(i_act), .i_wgt(i_wgt),
        .i_a_signed(i_a_signed), .i_w_signed(i_w_signed), .i_shift(i_shift),
        .o_pe_activation(o_pe_activation), .o_pe_weight(o_pe_weight),
        .o_pe_A_signed(o_pe_A_signed), .o_pe_W_signed(o_pe_W_signed),
        .o_pe_shift_amount(o_pe_shift_amount), .i_pe_prod(pe_q), .o_valid(o_valid),
        .i_ready(i_ready), .o_sum(o_sum), .o_err(o_err)
    );

    // Dot product of 16 two-bit bricks, then the legal shift (anything else: no shift)
    function automatic int pe_fn(input logic [31:0] a, input logic [31:0] w,
                                 input logic as, input logic ws, input logic [3:0] sh);
        int s;
        int av;
        int wv;
        s = 0;
        for (int i = 0; i < 16; i++) begin
            av = int'(a[2*i +: 2]);
            wv = int'(w[2*i +: 2]);
            if (as && a[2*i+1]) av = av - 4;
            if (ws && w[2*i+1]) wv = wv - 4;
            s = s + av * wv;
        end
        if (sh == 4'd2) s = s * 4;
        else if (sh == 4'd4) s = s * 16;
        return s;
    endfunction

    // PE with a one-cycle output register that is deliberately never reset
    always_ff @(posedge clk) begin
        pe_q <= PROD_W'(pe_fn(o_pe_activation, o_pe_weight, o_pe_A_signed,
                              o_pe_W_signed, o_pe_shift_amount));
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic run_job(input int len, input int gap, input int hold,
                           input logic [ACC_W-1:0] exp_sum, input logic exp_err,
                           input string nm);
        int  k;
        int  cyc;
        int  guard;
        logic rdy;
        logic v;
        i_start = 1'b1;
        i_len   = LEN_W'(len);
        @(negedge clk);
        i_start = 1'b0;
        cyc = 1;
        k = 0;
        guard = 0;
        while (k < len && guard < 200) begin
            rdy = o_ready;
            if (gap == 0) v = 1'b1;
            else if (gap == 1) v = (guard % 2 == 0);
            else v = 1'($urandom_range(0, 1));
            i_valid = v;
            i_act = b_act[k]; i_wgt = b_wgt[k];
            i_a_signed = b_as[k]; i_w_signed = b_ws[k]; i_shift = b_sh[k];
            #1;
            if (v && rdy) begin
                chk({nm, "_pe_act"}, o_pe_activation, b_act[k]);
                chk({nm, "_pe_shift"}, {28'd0, o_pe_shift_amount}, {28'd0, b_sh[k]});
                k++;
            end else begin
                chk({nm, "_pe_idle"}, o_pe_activation, 32'd0);
            end
            @(negedge clk);
            cyc++;
            guard++;
        end
        i_valid = 1'b0;
        i_act = 32'd0; i_wgt = 32'd0; i_shift = 4'd0;
        i_a_signed = 1'b0; i_w_signed = 1'b0;
        while (!o_valid && guard < 200) begin
            @(negedge clk);
            cyc++;
            guard++;
        end
        chk({nm, "_valid"}, {31'd0, o_valid}, 32'd1);
        if (gap == 0) chk({nm, "_latency"}, cyc, (len == 0) ? 32'd1 : 32'(len + 2));
        chk({nm, "_sum"}, {8'd0, o_sum}, {8'd0, exp_sum});
        chk({nm, "_err"}, {31'd0, o_err}, {31'd0, exp_err});
        chk({nm, "_ready_done"}, {31'd0, o_ready}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            i_start = 1'b1;
            @(negedge clk);
            chk({nm, "_hold_valid"}, {31'd0, o_valid}, 32'd1);
            chk({nm, "_hold_sum"}, {8'd0, o_sum}, {8'd0, exp_sum});
        end
        i_start = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        chk({nm, "_idle_valid"}, {31'd0, o_valid}, 32'd0);
        chk({nm, "_idle_busy"}, {31'd0, o_busy}, 32'd0);
    endtask

    typedef struct {
        int          len;
        logic [31:0] act;
        logic [31:0] wgt;
        logic        as;
        logic        ws;
        logic [3:0]  sh0;
        logic [3:0]  sh1;
        logic [3:0]  sh2;
        int          gap;
        int          hold;
        logic [23:0] sum;
        logic        err;
    } vec_t;

    vec_t vt [8];

    initial begin
        logic [3:0] sh_pool [8];
        int total;
        logic exp_e;
        int len;
        logic seen;

        vt[0] = '{1, 32'h1, 32'h1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 0, 0, 24'd1, 1'b0};
        vt[1] = '{3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'd0, 4'd2, 4'd4, 0, 5, 24'd336, 1'b0};
        vt[2] = '{4, 32'h1, 32'h1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1, 0, 24'd4, 1'b0};
        vt[3] = '{0, 32'h1, 32'h1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 0, 0, 24'd0, 1'b0};
        vt[4] = '{1, 32'h1, 32'h1, 1'b0, 1'b0, 4'd3, 4'd0, 4'd0, 0, 0, 24'd1, 1'b1};
        vt[5] = '{1, 32'h1, 32'h1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 0, 0, 24'd1, 1'b0};
        vt[6] = '{3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 0, 1, 24'd432, 1'b0};
        vt[7] = '{2, 32'hFFFF_FFFF, 32'h5555_5555, 1'b1, 1'b0, 4'd2, 4'd2, 4'd2, 0, 0, 24'hFFFF80, 1'b0};
        sh_pool = '{4'd0, 4'd2, 4'd4, 4'd0, 4'd2, 4'd4, 4'd1, 4'd3};

        i_rst = 1'b1; i_start = 1'b0; i_len = '0; i_valid = 1'b0; i_ready = 1'b0;
        i_act = 32'd0; i_wgt = 32'd0; i_a_signed = 1'b0; i_w_signed = 1'b0; i_shift = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_sum", {8'd0, o_sum}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        i_rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < vt[v].len; k++) begin
                b_act[k] = vt[v].act; b_wgt[k] = vt[v].wgt;
                b_as[k] = vt[v].as; b_ws[k] = vt[v].ws;
                b_sh[k] = (k % 3 == 0) ? vt[v].sh0 : (k % 3 == 1) ? vt[v].sh1 : vt[v].sh2;
            end
            run_job(vt[v].len, vt[v].gap, vt[v].hold, vt[v].sum, vt[v].err, $sformatf("vec%0d", v));
        end

        // Reset after two of four beats, with a third beat in flight into the PE
        i_start = 1'b1; i_len = LEN_W'(4);
        @(negedge clk);
        i_start = 1'b0;
        i_valid = 1'b1; i_act = 32'h1; i_wgt = 32'h1; i_shift = 4'd0;
        repeat (2) @(negedge clk);
        i_act = 32'hFFFF_FFFF; i_wgt = 32'hFFFF_FFFF; i_shift = 4'd4; i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0; i_valid = 1'b0; i_act = 32'd0; i_wgt = 32'd0; i_shift = 4'd0;
        chk("midrst_busy", {31'd0, o_busy}, 32'd0);
        chk("midrst_ready", {31'd0, o_ready}, 32'd0);
        chk("midrst_sum", {8'd0, o_sum}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        chk("midrst_no_valid", {31'd0, seen}, 32'd0);
        b_act[0] = 32'h1; b_wgt[0] = 32'h1; b_as[0] = 1'b0; b_ws[0] = 1'b0; b_sh[0] = 4'd0;
        run_job(1, 0, 0, 24'd1, 1'b0, "after_rst");

        for (int j = 0; j < 40; j++) begin
            len = int'($urandom_range(0, 6));
            total = 0;
            exp_e = 1'b0;
            for (int k = 0; k < len; k++) begin
                b_act[k] = $urandom; b_wgt[k] = $urandom;
                b_as[k] = 1'($urandom_range(0, 1)); b_ws[k] = 1'($urandom_range(0, 1));
                b_sh[k] = sh_pool[$urandom_range(0, 7)];
                total = total + pe_fn(b_act[k], b_wgt[k], b_as[k], b_ws[k], b_sh[k]);
                if (!(b_sh[k] == 4'd0 || b_sh[k] == 4'd2 || b_sh[k] == 4'd4)) exp_e = 1'b1;
            end
            run_job(len, 2, int'($urandom_range(0, 2)), ACC_W'(total), exp_e, $sformatf("rnd%0d", j));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
